// File: rtl/pri_arb_pkg.sv
// Shared types and helpers for the priority / round-robin arbiter.
package pri_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // Index width that stays at least 1 bit for tiny requester counts.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pri_select.sv
// Combinational pick: highest set request at or below ptr (RR), else highest overall.
module pri_select
   import pri_arb_pkg::*;
#(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             rr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   logic             m_hit;
   logic [IDX_W-1:0] m_idx;
   logic             u_hit;
   logic [IDX_W-1:0] u_idx;

   // Ascending scan: the last set bit seen is the highest one.
   always_comb begin
      m_hit = 1'b0;
      m_idx = '0;
      u_hit = 1'b0;
      u_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i]) begin
            u_hit = 1'b1;
            u_idx = IDX_W'(i);
            if (IDX_W'(i) <= ptr) begin
               m_hit = 1'b1;
               m_idx = IDX_W'(i);
            end
         end
      end
   end

   assign any = u_hit;
   assign idx = (rr && m_hit) ? m_idx : u_idx;

   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < N; i++) begin
         onehot[i] = u_hit && (idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/pri_arbiter_rr.sv
// Registered N-way arbiter: grant held until done or watchdog expiry, fixed or RR order.
module pri_arbiter_rr
   import pri_arb_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned IDX_W   = idx_width(N),
   parameter int unsigned RR      = 1,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             en,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   state_e           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             vld_q, vld_d;
   logic             to_q, to_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             sel_any;
   logic [IDX_W-1:0] sel_idx;
   logic [N-1:0]     sel_onehot;
   logic             expire;
   logic             release_c;
   logic             start;

   pri_select #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_sel (
      .req    (req),
      .ptr    (ptr_q),
      .rr     (RR != 0),
      .any    (sel_any),
      .idx    (sel_idx),
      .onehot (sel_onehot)
   );

   // done wins over expiry, so a coincident done never raises timeout.
   assign expire    = (TIMEOUT != 0) && (state_q == ST_GRANT) &&
                      (cnt_q == CW'(TMAX)) && !done;
   assign release_c = (state_q == ST_GRANT) && (done || expire);
   assign start     = en && sel_any && ((state_q == ST_IDLE) || release_c);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      to_d    = expire;
      if (start) begin
         state_d = ST_GRANT;
         gnt_d   = sel_onehot;
         idx_d   = sel_idx;
         vld_d   = 1'b1;
         cnt_d   = '0;
         ptr_d   = (sel_idx == '0) ? IDX_W'(N - 1) : sel_idx - IDX_W'(1);
      end else if (release_c || (state_q == ST_IDLE)) begin
         state_d = ST_IDLE;
         gnt_d   = '0;
         idx_d   = '0;
         vld_d   = 1'b0;
         cnt_d   = '0;
      end else if (TIMEOUT > 0) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
         ptr_q   <= IDX_W'(N - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;
   assign timeout = to_q;

endmodule

// File: tb/tb_pri_arbiter_rr.sv
// Directed bench for pri_arbiter_rr in several configurations plus pri_select alone.
module tb_pri_arbiter_rr;
   import pri_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       en;
   logic       done;

   logic [7:0] fp_gnt;  logic [2:0] fp_idx;  logic fp_vld;  logic fp_to;
   logic [7:0] rr_gnt;  logic [2:0] rr_idx;  logic rr_vld;  logic rr_to;
   logic [7:0] to_gnt;  logic [2:0] to_idx;  logic to_vld;  logic to_to;
   logic [4:0] n5_gnt;  logic [2:0] n5_idx;  logic n5_vld;  logic n5_to;

   logic [7:0] sel_req;
   logic [2:0] sel_ptr;
   logic       sel_rr;
   logic       sel_any;
   logic [2:0] sel_idx;
   logic [7:0] sel_oh;

   int vecs  = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pri_arbiter_rr #(.N(8), .RR(0), .TIMEOUT(0)) u_fp (
      .clk(clk), .rst(rst), .req(req), .en(en), .done(done),
      .gnt(fp_gnt), .gnt_idx(fp_idx), .gnt_vld(fp_vld), .timeout(fp_to));

   pri_arbiter_rr #(.N(8), .RR(1), .TIMEOUT(0)) u_rr (
      .clk(clk), .rst(rst), .req(req), .en(en), .done(done),
      .gnt(rr_gnt), .gnt_idx(rr_idx), .gnt_vld(rr_vld), .timeout(rr_to));

   pri_arbiter_rr #(.N(8), .RR(1), .TIMEOUT(4)) u_to (
      .clk(clk), .rst(rst), .req(req), .en(en), .done(done),
      .gnt(to_gnt), .gnt_idx(to_idx), .gnt_vld(to_vld), .timeout(to_to));

   pri_arbiter_rr #(.N(5), .RR(1), .TIMEOUT(0)) u_n5 (
      .clk(clk), .rst(rst), .req(req[4:0]), .en(en), .done(done),
      .gnt(n5_gnt), .gnt_idx(n5_idx), .gnt_vld(n5_vld), .timeout(n5_to));

   pri_select #(.N(8)) u_sel (
      .req(sel_req), .ptr(sel_ptr), .rr(sel_rr),
      .any(sel_any), .idx(sel_idx), .onehot(sel_oh));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp2[5];
      exp2 = '{7, 2, 0, 7, 2};
      rst  = 1'b1;
      en   = 1'b0;
      done = 1'b0;
      req  = '0;
      sel_req = '0;
      sel_ptr = '0;
      sel_rr  = 1'b0;
      step();
      step();
      chk("rst_gnt", 32'(fp_gnt), 32'h0);
      chk("rst_idx", 32'(fp_idx), 32'h0);
      chk("rst_vld", 32'(fp_vld), 32'h0);
      chk("rst_to",  32'(to_to),  32'h0);
      rst = 1'b0;

      // pri_select stand-alone
      sel_req = 8'b0100_1010; sel_ptr = 3'd4; sel_rr = 1'b1; #1;
      chk("sel_rr_idx", 32'(sel_idx), 32'd3);
      chk("sel_rr_oh",  32'(sel_oh),  32'h08);
      sel_rr = 1'b0; #1;
      chk("sel_fp_idx", 32'(sel_idx), 32'd6);
      sel_rr = 1'b1; sel_ptr = 3'd0; #1;
      chk("sel_wrap_idx", 32'(sel_idx), 32'd6);
      sel_req = '0; #1;
      chk("sel_none_any", 32'(sel_any), 32'd0);
      chk("sel_none_oh",  32'(sel_oh),  32'h0);

      // 1: fixed priority, highest index always wins
      req = 8'b0010_0110; en = 1'b1;
      chk("t1_pre_vld", 32'(fp_vld), 32'd0);
      step();
      chk("t1_gnt", 32'(fp_gnt), 32'h20);
      chk("t1_idx", 32'(fp_idx), 32'd5);
      chk("t1_vld", 32'(fp_vld), 32'd1);
      for (int k = 0; k < 3; k++) begin
         done = 1'b1; step(); done = 1'b0;
         chk("t1_regnt_gnt", 32'(fp_gnt), 32'h20);
         chk("t1_regnt_vld", 32'(fp_vld), 32'd1);
      end

      // 2: round-robin, done every second cycle
      do_reset();
      req = 8'b1000_0101; en = 1'b1;
      step();
      chk("t2_idx0", 32'(rr_idx), 32'(exp2[0]));
      for (int k = 1; k < 5; k++) begin
         step();
         chk("t2_hold", 32'(rr_idx), 32'(exp2[k-1]));
         done = 1'b1; step(); done = 1'b0;
         chk("t2_idx", 32'(rr_idx), 32'(exp2[k]));
         chk("t2_vld", 32'(rr_vld), 32'd1);
      end

      // 3: grant frozen while owner drops req and others request
      do_reset();
      req = 8'h08;
      step();
      chk("t3_gnt", 32'(rr_gnt), 32'h08);
      req = 8'h40;
      for (int k = 0; k < 10; k++) step();
      chk("t3_frozen_gnt", 32'(rr_gnt), 32'h08);
      chk("t3_frozen_idx", 32'(rr_idx), 32'd3);
      done = 1'b1; step(); done = 1'b0;
      chk("t3_next_idx", 32'(rr_idx), 32'd6);
      chk("t3_next_gnt", 32'(rr_gnt), 32'h40);

      // 4: watchdog expiry after exactly 4 cycles, then done in 4th cycle
      do_reset();
      req = 8'h02;
      step();
      chk("t4_gnt", 32'(to_gnt), 32'h02);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4_no_to", 32'(to_to), 32'd0);
         chk("t4_held", 32'(to_vld), 32'd1);
      end
      step();
      chk("t4_to_pulse", 32'(to_to), 32'd1);
      chk("t4_regnt_idx", 32'(to_idx), 32'd1);
      chk("t4_regnt_vld", 32'(to_vld), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4b_no_to", 32'(to_to), 32'd0);
      end
      done = 1'b1; req = '0;
      step();
      done = 1'b0;
      chk("t4b_done_to", 32'(to_to), 32'd0);
      chk("t4b_done_vld", 32'(to_vld), 32'd0);
      step();
      chk("t4b_after_to", 32'(to_to), 32'd0);

      // 5: N=5 round-robin pointer wrap
      do_reset();
      req = 8'h11;
      step();
      chk("t5_idx_a", 32'(n5_idx), 32'd4);
      chk("t5_gnt_a", 32'(n5_gnt), 32'h10);
      done = 1'b1; step(); done = 1'b0;
      chk("t5_idx_b", 32'(n5_idx), 32'd0);
      chk("t5_gnt_b", 32'(n5_gnt), 32'h01);
      done = 1'b1; step(); done = 1'b0;
      chk("t5_idx_c", 32'(n5_idx), 32'd4);
      chk("t5_vld_c", 32'(n5_vld), 32'd1);

      // 6: reset mid-grant, enable gating, pointer back to N-1
      do_reset();
      req = 8'hFF; en = 1'b1;
      step();
      done = 1'b1; step(); done = 1'b0;
      chk("t6_pre_idx", 32'(rr_idx), 32'd6);
      rst = 1'b1; en = 1'b0;
      step();
      chk("t6_rst_gnt", 32'(rr_gnt), 32'h0);
      chk("t6_rst_vld", 32'(rr_vld), 32'd0);
      chk("t6_rst_to",  32'(rr_to),  32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_en0_vld", 32'(rr_vld), 32'd0);
      end
      en = 1'b1;
      step();
      chk("t6_first_idx", 32'(rr_idx), 32'd7);
      chk("t6_first_gnt", 32'(rr_gnt), 32'h80);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

// File: doc/pri_arbiter_rr.md
Name: pri_arbiter_rr

Overview:
Registered, parametrised N-input arbiter built around a priority-select core. Accepts a request vector and issues one registered grant as one-hot, binary index and valid. The grant is held until the owner releases it or a watchdog expires. Supports fixed priority (highest index wins) or round-robin mode. Sits in front of shared resources: bus ports, FIFOs, output muxes.

Parameters:
N, 8, number of requesters (>=2, any value, need not be a power of 2)
IDX_W, $clog2(N), width of gnt_idx
RR, 1, 0 = fixed priority (highest index wins); 1 = round-robin
TIMEOUT, 0, max grant hold in cycles; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  N  request vector, bit i = requester i
en  in  1  arbitration enable; gates new grants only
done  in  1  owner releases the current grant (single-cycle pulse)
gnt  out  N  registered one-hot grant
gnt_idx  out  IDX_W  binary index of the granted requester
gnt_vld  out  1  grant active
timeout  out  1  one-cycle pulse: grant was force-released by the watchdog

Behaviour:
- Reset (rst=1 at a clock edge; rst has priority over all inputs): state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=N-1, hold counter cnt=0.
- State machine, 2 states:
  - IDLE: if en=1 and |req, then on the next edge the winner is registered: gnt=onehot(w), gnt_idx=w, gnt_vld=1, cnt=0, go to GRANT. Otherwise stay in IDLE with outputs at 0.
  - GRANT: gnt, gnt_idx and gnt_vld stay frozen whatever req or en do. This includes the owner dropping its req. Leave only on release.
  - Release: done=1, or watchdog expiry.
- Latency: 1 cycle from req/en sampled to gnt_vld.
- Selection (combinational, on the sampled req):
  - RR=0: highest set index wins.
  - RR=1: highest set index <= ptr wins. If no set bit is <= ptr, highest set index overall wins.
- Pointer: on each new grant to w, ptr <= (w==0) ? N-1 : w-1, which wraps for non-power-of-2 N. ptr is unused when RR=0 but still updates.
- Release handling:
  - If en=1 and |req in the release cycle, arbitrate in that same cycle using the updated ptr. The next grant lands the following edge: back-to-back, no bubble, gnt_vld stays 1.
  - Otherwise gnt=0, gnt_idx=0, gnt_vld=0 and state goes to IDLE.
  - The released requester may win again only through normal RR/fixed order.
- Watchdog (TIMEOUT>0):
  - cnt increments each GRANT cycle; width $clog2(TIMEOUT+1).
  - If cnt==TIMEOUT-1 and done=0, force release. The grant is therefore held exactly TIMEOUT cycles.
  - timeout=1 for the single cycle after the forced release; 0 at all other times.
- Simultaneous events:
  - done in the expiry cycle counts as a normal release, no timeout pulse.
  - done in IDLE is ignored.
  - req bits of non-owners during GRANT are ignored, not latched.
- Invariants: gnt is one-hot or zero; gnt==0 iff gnt_vld==0; gnt[gnt_idx]==1 when gnt_vld=1.
- Reset mid-grant: the grant drops on the next edge with no timeout pulse, and ptr returns to N-1.

Decomposition:
- Shared package pri_arb_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1
  - a clog2-safe width helper that returns 1 for N<=2
- One natural sub-module: pri_select, a purely combinational priority pick.
  - Inputs: req[N], ptr[IDX_W], rr.
  - Outputs: any, idx[IDX_W], onehot[N].
  - Built as two highest-set-bit searches: one over the ptr-masked req, one over the unmasked req.
  - Unit-tested separately.

Test Plan:
1. RR=0, N=8, en=1, req=8'b0010_0110 held; pulse done each grant → grants idx 5 every time; gnt=8'h20; gnt_vld asserted 1 cycle after req.
2. RR=1, N=8, req=8'b1000_0101 held, done pulsed every 2nd cycle → grant sequence 7,2,0,7,2 with no gnt_vld gaps.
3. Hold: grant idx 3, then drop req[3] and raise req[6] while done=0 for 10 cycles → gnt stays 8'h08; after done, next grant is idx 6.
4. TIMEOUT=4: single req[1], no done → gnt_vld high exactly 4 cycles, then timeout pulse 1 cycle; regrant idx 1 back-to-back since req still high. Repeat with done in the 4th cycle → no timeout pulse.
5. N=5 (non-power-of-2), RR=1, req=5'b10001 → grants 4,0,4; ptr wraps 0→4; gnt_idx never exceeds 4.
6. rst asserted mid-grant and en=0 with req=8'hFF → outputs all 0 next edge, no grant while en=0; first grant after en=1 is idx 7.
